// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the scoreboarded register file.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SWEEP = 1'b1;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, zero-register mask,
// write-to-read bypass and busy-bit lookup.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int NUM_REGS = 2**ADDR_W
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
   input  logic [NUM_REGS-1:0]             busy_i,
   input  logic [ADDR_W-1:0]               sr_i,
   input  logic                            wr_en_i,
   input  logic [ADDR_W-1:0]               wr_addr_i,
   input  logic [DATA_W-1:0]               wr_data_i,
   input  logic                            iss_en_i,
   input  logic [ADDR_W-1:0]               iss_addr_i,
   output logic [DATA_W-1:0]               rd_data_o,
   output logic                            busy_o
);
   logic zero_hit;
   logic byp_hit;

   assign zero_hit = (ZERO_REG != 0) && (sr_i == '0);
   assign byp_hit  = (BYPASS != 0) && wr_en_i && (wr_addr_i == sr_i);

   always_comb begin
      rd_data_o = regs_i[sr_i];
      busy_o    = busy_i[sr_i];
      if (zero_hit) begin
         rd_data_o = '0;
         busy_o    = 1'b0;
      end else if (byp_hit) begin
         // Retiring write clears busy unless a new producer issues this cycle.
         rd_data_o = wr_data_i;
         busy_o    = iss_en_i && (iss_addr_i == sr_i);
      end
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with busy scoreboard, two bypassed read ports and a
// one-entry-per-cycle soft-clear sweep.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              RegW,
   input  logic [ADDR_W-1:0] DR,
   input  logic [DATA_W-1:0] Reg_in,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [DATA_W-1:0] ReadReg1,
   output logic [DATA_W-1:0] ReadReg2,
   input  logic              Issue,
   input  logic [ADDR_W-1:0] Issue_DR,
   output logic              Busy1,
   output logic              Busy2,
   input  logic              CLR,
   output logic              Ready
);
   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS-1);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]             busy_q, busy_d;
   state_t                          state_q, state_d;
   logic [ADDR_W-1:0]               idx_q, idx_d;
   logic                            idle, wr_ok, iss_ok;

   assign idle   = (state_q == ST_IDLE);
   assign wr_ok  = idle && RegW  && !((ZERO_REG != 0) && (DR == '0));
   assign iss_ok = idle && Issue && !((ZERO_REG != 0) && (Issue_DR == '0));
   assign Ready  = idle;

   always_comb begin
      regs_d  = regs_q;
      busy_d  = busy_q;
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_ok) begin
               regs_d[DR] = Reg_in;
               busy_d[DR] = 1'b0;
            end
            // Issue after write so a same-address producer leaves busy set.
            if (iss_ok) busy_d[Issue_DR] = 1'b1;
            if (CLR) begin
               state_d = ST_SWEEP;
               idx_d   = '0;
            end
         end
         default: begin
            regs_d[idx_q] = '0;
            busy_d[idx_q] = 1'b0;
            idx_d         = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         regs_q  <= '0;
         busy_q  <= '0;
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd1 (
      .regs_i(regs_q), .busy_i(busy_q), .sr_i(SR1),
      .wr_en_i(wr_ok), .wr_addr_i(DR), .wr_data_i(Reg_in),
      .iss_en_i(iss_ok), .iss_addr_i(Issue_DR),
      .rd_data_o(ReadReg1), .busy_o(Busy1)
   );

   regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd2 (
      .regs_i(regs_q), .busy_i(busy_q), .sr_i(SR2),
      .wr_en_i(wr_ok), .wr_addr_i(DR), .wr_data_i(Reg_in),
      .iss_en_i(iss_ok), .iss_addr_i(Issue_DR),
      .rd_data_o(ReadReg2), .busy_o(Busy2)
   );
endmodule
